// File: rtl/d_drain_arbiter_pkg.sv
// rtl/d_drain_arbiter_pkg.sv - shared types and constants for the D0/D1 drain arbiter
package d_drain_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam int   BW_DEFAULT = 6;
    localparam logic SRC_D0     = 1'b0;
    localparam logic SRC_D1     = 1'b1;

endpackage

// File: rtl/d_drain_arbiter_rr_arb2.sv
// rtl/d_drain_arbiter_rr_arb2.sv - two-requester round-robin arbiter with last_sel history
module rr_arb2
    import d_drain_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic upd,
    input  logic upd_sel,
    output logic grant,
    output logic any
);

    logic last_sel;

    // last_sel resets to D1 so that D0 wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            last_sel <= SRC_D1;
        end else if (upd) begin
            last_sel <= upd_sel;
        end
    end

    always_comb begin
        grant = SRC_D0;
        if (req0 && req1) begin
            grant = ~last_sel;
        end else if (req1) begin
            grant = SRC_D1;
        end
        any = req0 | req1;
    end

endmodule

// File: rtl/d_drain_arbiter.sv
// rtl/d_drain_arbiter.sv - drains D0/D1 FIFOs into one tagged valid/ready stream; DRAIN_CNT_EN adds per-source counters
module d_drain_arbiter
    import d_drain_arbiter_pkg::*;
#(
    parameter int BW = BW_DEFAULT
`ifdef DRAIN_CNT_EN
    ,
    parameter int CW = 8
`endif
)
(
    input  logic          clk,
    input  logic          reset,
    input  logic          D0_empty,
    input  logic          D0_error_output,
    input  logic [BW-1:0] D0_data_out,
    output logic          D0_rd,
    input  logic          D1_empty,
    input  logic          D1_error_output,
    input  logic [BW-1:0] D1_data_out,
    output logic          D1_rd,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [BW-1:0] out_data,
    output logic          out_src,
    output logic          idle
`ifdef DRAIN_CNT_EN
    ,
    output logic [CW-1:0] cnt_d0,
    output logic [CW-1:0] cnt_d1
`endif
);

    state_t state;
    state_t state_nxt;
    logic   sel;
    logic   d0_ok;
    logic   d1_ok;
    logic   grant;
    logic   any_ok;

    assign d0_ok = ~D0_empty & ~D0_error_output;
    assign d1_ok = ~D1_empty & ~D1_error_output;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req0    (d0_ok),
        .req1    (d1_ok),
        .upd     (state == RD),
        .upd_sel (sel),
        .grant   (grant),
        .any     (any_ok)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sel      <= SRC_D0;
            out_data <= '0;
            out_src  <= SRC_D0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_ok) begin
                sel <= grant;
            end
            // FIFO read data is valid the cycle after the pop strobe
            if (state == CAP) begin
                out_data <= (sel == SRC_D1) ? D1_data_out : D0_data_out;
                out_src  <= sel;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (any_ok)    state_nxt = RD;
            RD:                  state_nxt = CAP;
            CAP:                 state_nxt = HOLD;
            HOLD: if (out_ready) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // Strobes decode purely from registers, so they cannot glitch or overlap
    assign D0_rd     = (state == RD) && (sel == SRC_D0);
    assign D1_rd     = (state == RD) && (sel == SRC_D1);
    assign out_valid = (state == HOLD);
    assign idle      = (state == IDLE) && !d0_ok && !d1_ok;

`ifdef DRAIN_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_d0 <= '0;
            cnt_d1 <= '0;
        end else if (out_valid && out_ready) begin
            if (out_src == SRC_D1) begin
                cnt_d1 <= cnt_d1 + 1'b1;
            end else begin
                cnt_d0 <= cnt_d0 + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_d_drain_arbiter.sv
// tb/tb_d_drain_arbiter.sv - directed self-checking bench for d_drain_arbiter with behavioural FIFOs
module tb_d_drain_arbiter;

    localparam int BW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          D0_empty, D0_error_output, D0_rd;
    logic          D1_empty, D1_error_output, D1_rd;
    logic [BW-1:0] D0_data_out, D1_data_out;
    logic          out_ready, out_valid, out_src, idle;
    logic [BW-1:0] out_data;
`ifdef DRAIN_CNT_EN
    logic [1:0]    cnt_d0, cnt_d1;
`endif

    always #5 clk = ~clk;

`ifdef DRAIN_CNT_EN
    d_drain_arbiter #(.BW(BW), .CW(2)) dut (
`else
    d_drain_arbiter #(.BW(BW)) dut (
`endif
        .clk             (clk),
        .reset           (reset),
        .D0_empty        (D0_empty),
        .D0_error_output (D0_error_output),
        .D0_data_out     (D0_data_out),
        .D0_rd           (D0_rd),
        .D1_empty        (D1_empty),
        .D1_error_output (D1_error_output),
        .D1_data_out     (D1_data_out),
        .D1_rd           (D1_rd),
        .out_ready       (out_ready),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_src         (out_src),
        .idle            (idle)
`ifdef DRAIN_CNT_EN
        ,
        .cnt_d0          (cnt_d0),
        .cnt_d1          (cnt_d1)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_rd0, n_rd1;
    int c0;
    logic [BW-1:0] q0[$], q1[$];
    logic [BW-1:0] hs_data[$];
    logic          hs_src[$];
    int            hs_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample DUT at the negedge, then let the FIFO model react to pops
    task automatic tick();
        logic r0, r1;
        #1;
        r0 = D0_rd;
        r1 = D1_rd;
        if (D0_rd) n_rd0++;
        if (D1_rd) n_rd1++;
        if (out_valid && out_ready) begin
            hs_data.push_back(out_data);
            hs_src.push_back(out_src);
            hs_cyc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        #1;
        if (r0 && q0.size() > 0) D0_data_out = q0.pop_front();
        if (r1 && q1.size() > 0) D1_data_out = q1.pop_front();
        D0_empty = (q0.size() == 0);
        D1_empty = (q1.size() == 0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q0.delete();
        q1.delete();
        D0_empty = 1'b1;
        D1_empty = 1'b1;
        D0_error_output = 1'b0;
        D1_error_output = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        hs_data.delete();
        hs_src.delete();
        hs_cyc.delete();
        n_rd0 = 0;
        n_rd1 = 0;
    endtask

    task automatic run_until_hs(input int n, input int budget);
        for (int k = 0; k < budget && hs_data.size() < n; k++) tick();
        check("hs_count", hs_data.size(), n);
    endtask

    initial begin
        D0_data_out = '0;
        D1_data_out = '0;
        out_ready = 1'b1;
        @(negedge clk);
        do_reset();

        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_src", out_src, 0);
        check("rst_D0_rd", D0_rd, 0);
        check("rst_D1_rd", D1_rd, 0);
        check("rst_idle", idle, 1);

        // D0 only, three words
        q0 = '{6'h21, 6'h3F, 6'h2C};
        D0_empty = 1'b0;
        run_until_hs(3, 40);
        if (hs_data.size() == 3) begin
            check("t1_w0", hs_data[0], 6'h21);
            check("t1_w1", hs_data[1], 6'h3F);
            check("t1_w2", hs_data[2], 6'h2C);
            check("t1_src", {hs_src[0], hs_src[1], hs_src[2]}, 3'b000);
        end
        tick();
        tick();
        check("t1_rd0_pulses", n_rd0, 3);
        check("t1_rd1_pulses", n_rd1, 0);

        // Both FIFOs with four words: strict alternation starting at D0
        do_reset();
        q0 = '{6'h01, 6'h02, 6'h03, 6'h04};
        q1 = '{6'h11, 6'h12, 6'h13, 6'h14};
        D0_empty = 1'b0;
        D1_empty = 1'b0;
        c0 = cyc;
        run_until_hs(8, 60);
        if (hs_data.size() == 8) begin
            check("t2_src", {hs_src[0], hs_src[1], hs_src[2], hs_src[3],
                             hs_src[4], hs_src[5], hs_src[6], hs_src[7]}, 8'b01010101);
            check("t2_w0", hs_data[0], 6'h01);
            check("t2_w1", hs_data[1], 6'h11);
            check("t2_w6", hs_data[6], 6'h04);
            check("t2_w7", hs_data[7], 6'h14);
            check("t2_lat0", hs_cyc[0] - c0, 3);
            check("t2_lat7", hs_cyc[7] - c0, 31);
        end

        // Backpressure in HOLD
        do_reset();
        out_ready = 1'b0;
        q0 = '{6'h35};
        D0_empty = 1'b0;
        for (int k = 0; k < 10 && !out_valid; k++) tick();
        check("t3_valid_up", out_valid, 1);
        n_rd0 = 0;
        n_rd1 = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_hold_data", out_data, 6'h35);
            check("t3_hold_valid", out_valid, 1);
        end
        check("t3_no_rd", n_rd0 + n_rd1, 0);
        out_ready = 1'b1;
        tick();
        check("t3_hs", hs_data.size(), 1);
        check("t3_valid_down", out_valid, 0);
        check("t3_idle", idle, 1);

        // D1 in error: only D0 drains
        do_reset();
        D1_error_output = 1'b1;
        q1 = '{6'h2A};
        q0 = '{6'h05, 6'h06};
        D0_empty = 1'b0;
        D1_empty = 1'b0;
        run_until_hs(2, 30);
        if (hs_data.size() == 2) begin
            check("t4_w0", {hs_src[0], hs_data[0]}, {1'b0, 6'h05});
            check("t4_w1", {hs_src[1], hs_data[1]}, {1'b0, 6'h06});
        end
        tick();
        tick();
        check("t4_rd1_pulses", n_rd1, 0);
        check("t4_idle", idle, 1);

        // Reset in CAP: popped word is lost, next pop starts at D0
        do_reset();
        q0 = '{6'h07, 6'h08};
        q1 = '{6'h18};
        D0_empty = 1'b0;
        D1_empty = 1'b0;
        for (int k = 0; k < 10 && !D0_rd; k++) tick();
        check("t5_rd0_seen", D0_rd, 1);
        tick();
        reset = 1'b1;
        tick();
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_data", out_data, 0);
        check("t5_rst_rd", {D0_rd, D1_rd}, 2'b00);
        reset = 1'b0;
        hs_data.delete();
        hs_src.delete();
        hs_cyc.delete();
        run_until_hs(2, 30);
        if (hs_data.size() == 2) begin
            check("t5_w0", {hs_src[0], hs_data[0]}, {1'b0, 6'h08});
            check("t5_w1", {hs_src[1], hs_data[1]}, {1'b1, 6'h18});
        end

`ifdef DRAIN_CNT_EN
        do_reset();
        check("cnt_rst_d0", cnt_d0, 0);
        q0 = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05};
        D0_empty = 1'b0;
        run_until_hs(5, 40);
        tick();
        check("cnt_d0_wrap", cnt_d0, 1);
        check("cnt_d1_zero", cnt_d1, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/d_drain_arbiter.md
Name: d_drain_arbiter

Overview:
- Downstream consumer of the D0/D1 destination FIFOs of the QoS path (the FIFOs fed by the Main→VC→D chain).
- Pops words from D0 and D1 under a round-robin arbiter and merges them into one valid/ready output stream, tagging each word with its source FIFO.
- Replaces manual D0_rd/D1_rd driving, so the whole path drains autonomously.

Parameters:
- BW, 6: data word width; matches Main/VC/D FIFO width.
- CW, 8: width of per-source word counters (optional feature).

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- D0_empty  input  1  D0 FIFO empty flag.
- D0_error_output  input  1  D0 FIFO error flag; D0 is ineligible while high.
- D0_data_out  input  BW  D0 read data, valid the cycle after D0_rd.
- D0_rd  output  1  D0 pop strobe.
- D1_empty  input  1  D1 FIFO empty flag.
- D1_error_output  input  1  D1 FIFO error flag; D1 is ineligible while high.
- D1_data_out  input  BW  D1 read data, valid the cycle after D1_rd.
- D1_rd  output  1  D1 pop strobe.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_valid  output  1  out_data/out_src hold a word.
- out_data  output  BW  merged word.
- out_src  output  1  0 = word came from D0, 1 = word came from D1.
- idle  output  1  high when in IDLE and neither FIFO is eligible.

Behaviour:
- Eligibility: Dn_ok = ~Dn_empty & ~Dn_error_output.
- States:
  - IDLE: if D0_ok or D1_ok, register sel and go to RD.
  - RD: assert D{sel}_rd for exactly one cycle, then go to CAP.
  - CAP: latch D{sel}_data_out into out_data, set out_src = sel, go to HOLD.
  - HOLD: out_valid = 1. On out_ready, go to IDLE.
- Arbitration:
  - If both FIFOs are eligible, pick ~last_sel.
  - If only one is eligible, pick it.
  - last_sel updates to sel when leaving RD.
  - Reset value of last_sel is 1, so D0 wins the first tie.
- Rd strobes:
  - Decoded from registered state and sel; they are glitch-free and never both high.
  - Dn_rd is never asserted while in IDLE, CAP or HOLD.
- Latency: an eligible FIFO sampled in IDLE at cycle N gives Dn_rd at N+1 and out_valid at N+3. Throughput is at most one word per 4 cycles.
- Eligibility is sampled only in IDLE. An error or empty that rises during RD does not cancel the pop already issued.
- Output hold: while out_valid=1 and out_ready=0, out_data and out_src hold stable. out_valid deasserts the cycle after the handshake cycle.
- Reset, including mid-operation: state = IDLE, out_valid = 0, out_data = 0, out_src = 0, D0_rd = D1_rd = 0, last_sel = 1. An in-flight word is discarded; the FIFO pop, if already issued, is not replayed.
- idle = (state == IDLE) & ~D0_ok & ~D1_ok. Its reset value follows the inputs.

Optional Feature:
- Macro: DRAIN_CNT_EN.
- Defined: adds outputs cnt_d0 [CW-1:0] and cnt_d1 [CW-1:0].
  - The matching counter increments on each accepted handshake (out_valid & out_ready), by out_src.
  - Counters wrap from 2^CW-1 to 0 and reset to 0.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, RD, CAP, HOLD);
  - the BW default;
  - the source encoding constants SRC_D0 = 0 and SRC_D1 = 1.
- One natural sub-module, rr_arb2: a 2-requester round-robin with a last_sel register.
- FSM and datapath stay in the top module.

Test Plan:
- Reset, then D0 with 3 words (0x21, 0x3F, 0x2C), D1 empty, out_ready=1 → out_data emits 0x21, 0x3F, 0x2C in order with out_src=0; D0_rd pulses exactly 3 times; D1_rd never pulses.
- Both FIFOs hold 4 words, out_ready=1 → out_src sequence is 0,1,0,1,0,1,0,1; each word appears 3 cycles after its IDLE sample.
- Word 0x35 in HOLD with out_ready=0 for 5 cycles → out_data stays 0x35, out_valid stays 1, no rd pulses; ready high → one handshake, then IDLE.
- D1_error_output=1 while D1 is non-empty and D0 holds 2 words → only D0 drains; idle=1 after D0 empties, with D1 still non-empty.
- Reset asserted in CAP → next cycle out_valid=0 and state IDLE; the FIFO lost one word; the next pop starts on D0.
- With DRAIN_CNT_EN and CW=2 → after 5 D0 handshakes cnt_d0=1 (wrapped), cnt_d1=0.
